// File: rtl/vga_pkg.sv
// Shared 1024x768@60 raster constants and update-handshake state encoding,
// used by the timing generator and the writer-side blocks that follow its grants.
package vga_pkg;
  localparam int HW  = 11;
  localparam int VW  = 10;
  localparam int FCW = 16;

  localparam int VGA_H_ACTIVE = 1024;
  localparam int VGA_H_FP     = 24;
  localparam int VGA_H_SYNC   = 136;
  localparam int VGA_H_BP     = 160;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 768;
  localparam int VGA_V_FP     = 3;
  localparam int VGA_V_SYNC   = 6;
  localparam int VGA_V_BP     = 29;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync windows are [start, end): end is the first index with sync released.
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ACK   = 2'd2
  } upd_state_t;
endpackage

// File: rtl/vga_counter.sv
// Horizontal/vertical raster counter pair; registered counts plus their next values, one-cycle latency.
// No backpressure: advances every vclock, synchronous active-low reset to 0,0.
module vga_counter
  import vga_pkg::*;
#(
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL
) (
  input  logic          vclock,
  input  logic          reset_n,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic [HW-1:0] hcount_nxt,
  output logic [VW-1:0] vcount_nxt
);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic h_wrap;

  always_comb begin
    h_wrap     = (hcount == H_LAST);
    hcount_nxt = h_wrap ? '0 : hcount + HW'(1);
    vcount_nxt = vcount;
    if (h_wrap) begin
      vcount_nxt = (vcount == V_LAST) ? '0 : vcount + VW'(1);
    end
  end

  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing plus a vertical-blanking update handshake; every output registered and aligned to hcount/vcount.
// No backpressure; VGA_TIMING_FRAME_COUNTER_EN adds a completed-frame counter, otherwise frame_count is tied to 0.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic           vclock,
  input  logic           reset_n,
  input  logic           update_req,
  output logic [HW-1:0]  hcount,
  output logic [VW-1:0]  vcount,
  output logic           hsync,
  output logic           vsync,
  output logic           blank,
  output logic           frame_start,
  output logic           update_ack,
  output logic [FCW-1:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          grant_pt;
  logic          next_frame_start;
  upd_state_t    state;
  logic          ack_holdoff;

  vga_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_counter (
    .vclock    (vclock),
    .reset_n   (reset_n),
    .hcount    (hcount),
    .vcount    (vcount),
    .hcount_nxt(h_nxt),
    .vcount_nxt(v_nxt)
  );

  // Decoding the next position keeps the flags in step with the registered counts.
  assign grant_pt         = (h_nxt == '0) && (v_nxt == V_ACT);
  assign next_frame_start = (h_nxt == '0) && (v_nxt == '0);

  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b1;
    end else begin
      hsync       <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
      vsync       <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
      blank       <= (h_nxt >= H_ACT) || (v_nxt >= V_ACT);
      frame_start <= next_frame_start;
    end
  end

  // The ack lands on the cycle showing the first blanking line at hcount 0.
  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      state       <= IDLE;
      update_ack  <= 1'b0;
      ack_holdoff <= 1'b0;
    end else begin
      update_ack  <= 1'b0;
      ack_holdoff <= 1'b0;
      case (state)
        IDLE: begin
          if (update_req && !ack_holdoff) state <= ARMED;
        end
        ARMED: begin
          if (!update_req) begin
            state <= IDLE;
          end else if (grant_pt) begin
            state      <= ACK;
            update_ack <= 1'b1;
          end
        end
        ACK: begin
          state       <= IDLE;
          ack_holdoff <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (next_frame_start) begin
      frame_count <= frame_count + FCW'(1);
    end
  end
`else
  assign frame_count = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-raster instance driven with scenario and random stimulus,
// plus a default-parameter instance checked over its first lines.
module tb_vga_timing_gen;
  localparam int HA = 16, HFP = 3, HSY = 5, HBP = 4;
  localparam int VA = 10, VFP = 2, VSY = 3, VBP = 4;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic        ack;
    logic [15:0] fc;
  } obs_t;

  logic        vclock = 1'b0;
  logic        reset_n = 1'b0;
  logic        update_req = 1'b0;
  logic        req_def = 1'b0;
  logic [10:0] hcount, d_hcount;
  logic [9:0]  vcount, d_vcount;
  logic        hsync, vsync, blank, frame_start, update_ack;
  logic        d_hsync, d_vsync, d_blank, d_frame_start, d_update_ack;
  logic [15:0] frame_count, d_frame_count;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .vclock(vclock), .reset_n(reset_n), .update_req(update_req),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .blank(blank), .frame_start(frame_start), .update_ack(update_ack),
    .frame_count(frame_count)
  );

  vga_timing_gen dut_def (
    .vclock(vclock), .reset_n(reset_n), .update_req(req_def),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .blank(d_blank), .frame_start(d_frame_start), .update_ack(d_update_ack),
    .frame_count(d_frame_count)
  );

  always #5 vclock = ~vclock;

  int   n = 0;
  bit   r1 = 1'b0, r2 = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  obs_t o, e;

  // Expected outputs from the cycle count since reset and the last two sampled requests.
  function automatic obs_t model(int cyc, bit s1, bit s2, int ha, int hfp, int hsy, int hbp,
                                 int va, int vfp, int vsy, int vbp);
    obs_t m;
    int ht, vt, h, v;
    ht    = ha + hfp + hsy + hbp;
    vt    = va + vfp + vsy + vbp;
    h     = cyc % ht;
    v     = (cyc / ht) % vt;
    m.h   = 11'(h);
    m.v   = 10'(v);
    m.hs  = !(h >= ha + hfp && h < ha + hfp + hsy);
    m.vs  = !(v >= va + vfp && v < va + vfp + vsy);
    m.bl  = (h >= ha) || (v >= va);
    m.fs  = (h == 0) && (v == 0);
    m.ack = (h == 0) && (v == va) && s1 && s2;
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    m.fc  = 16'(cyc / (ht * vt));
`else
    m.fc  = 16'd0;
`endif
    return m;
  endfunction

  function automatic obs_t model_s();
    return model(n, r1, r2, HA, HFP, HSY, HBP, VA, VFP, VSY, VBP);
  endfunction

  function automatic obs_t obs();
    return {hcount, vcount, hsync, vsync, blank, frame_start, update_ack, frame_count};
  endfunction

  function automatic obs_t obs_d();
    return {d_hcount, d_vcount, d_hsync, d_vsync, d_blank, d_frame_start, d_update_ack, d_frame_count};
  endfunction

  function automatic int cur_h();
    return n % HT;
  endfunction

  function automatic int cur_v();
    return (n / HT) % VT;
  endfunction

  task automatic tick();
    @(posedge vclock);
    if (!reset_n) begin
      n = 0; r1 = 1'b0; r2 = 1'b0;
    end else begin
      n++; r2 = r1; r1 = update_req;
    end
    #1;
  endtask

  task automatic test_reset();
    obs_t rst;
    int   len;
    rst = '{h: 11'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b1, ack: 1'b0, fc: 16'd0};
    reset_n = 1'b0;
    len = 3 + int'($urandom_range(0, 4));
    for (int i = 0; i < len; i++) begin
      update_req = 1'($urandom_range(0, 1));
      tick();
      o = obs(); compared++;
      if (o !== rst) begin mismatched++; $display("FAIL reset_state got=%h exp=%h", o, rst); end
      o = obs_d(); compared++;
      if (o !== rst) begin mismatched++; $display("FAIL reset_state_def got=%h exp=%h", o, rst); end
    end
    update_req = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_line();
    int lo_start, lo_len, prev_v;
    while (cur_h() != 0) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL line_align n=%0d got=%h exp=%h", n, o, e); end
    end
    lo_start = -1; lo_len = 0; prev_v = int'(vcount);
    for (int i = 0; i < HT; i++) begin
      if (!hsync) begin
        if (lo_start < 0) lo_start = int'(hcount);
        lo_len++;
      end
      if (i < HT - 1) begin
        tick(); o = obs(); e = model_s(); compared++;
        if (o !== e) begin mismatched++; $display("FAIL line_cycle n=%0d got=%h exp=%h", n, o, e); end
      end
    end
    compared++;
    if (lo_start != HA + HFP || lo_len != HSY) begin
      mismatched++;
      $display("FAIL hsync_window start=%0d len=%0d exp start=%0d len=%0d", lo_start, lo_len, HA + HFP, HSY);
    end
    tick();
    compared++;
    if (hcount !== 11'd0 || int'(vcount) != (prev_v + 1) % VT) begin
      mismatched++;
      $display("FAIL line_wrap h=%0d v=%0d exp h=0 v=%0d", hcount, vcount, (prev_v + 1) % VT);
    end
  endtask

  task automatic test_frames();
    int fs_at[$];
    int vs_cnt, vs_first_v, vs_first_h;
    while (n % FRAME != 0) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL frames_align n=%0d got=%h exp=%h", n, o, e); end
    end
    vs_cnt = 0; vs_first_v = -1; vs_first_h = -1;
    for (int i = 0; i <= 2 * FRAME; i++) begin
      if (i > 0) begin
        tick(); o = obs(); e = model_s(); compared++;
        if (o !== e) begin mismatched++; $display("FAIL frames_cycle n=%0d got=%h exp=%h", n, o, e); end
      end
      if (frame_start) fs_at.push_back(n);
      if (!vsync && i < 2 * FRAME) begin
        if (vs_first_v < 0) begin vs_first_v = int'(vcount); vs_first_h = int'(hcount); end
        vs_cnt++;
      end
    end
    compared++;
    if (fs_at.size() != 3 || fs_at[1] - fs_at[0] != FRAME || fs_at[2] - fs_at[1] != FRAME) begin
      mismatched++;
      $display("FAIL frame_start_spacing pulses=%0d exp 3 spaced %0d", fs_at.size(), FRAME);
    end
    compared++;
    if (vs_cnt != 2 * VSY * HT || vs_first_v != VA + VFP || vs_first_h != 0) begin
      mismatched++;
      $display("FAIL vsync_window cycles=%0d first=%0d,%0d exp cycles=%0d first=%0d,0",
               vs_cnt, vs_first_v, vs_first_h, 2 * VSY * HT, VA + VFP);
    end
  endtask

  task automatic test_update_held();
    int acks, bad_pos;
    acks = 0; bad_pos = 0;
    while (!(cur_v() == 2 && cur_h() == 0)) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL held_align n=%0d got=%h exp=%h", n, o, e); end
    end
    update_req = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL held_cycle n=%0d got=%h exp=%h", n, o, e); end
      if (update_ack) begin
        acks++;
        if (vcount !== 10'(VA) || hcount !== 11'd0) bad_pos++;
      end
    end
    update_req = 1'b0;
    compared++;
    if (acks != 3 || bad_pos != 0) begin
      mismatched++;
      $display("FAIL held_ack_count acks=%0d misplaced=%0d exp acks=3 misplaced=0", acks, bad_pos);
    end
  endtask

  task automatic test_update_drop();
    int acks;
    acks = 0;
    while (!(cur_v() == 4 && cur_h() == 0)) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL drop_align n=%0d got=%h exp=%h", n, o, e); end
    end
    update_req = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL drop_cycle n=%0d got=%h exp=%h", n, o, e); end
      if (update_ack) acks++;
      if (cur_v() == 6 && cur_h() == 0) update_req = 1'b0;
    end
    compared++;
    if (acks != 0) begin mismatched++; $display("FAIL drop_no_ack acks=%0d exp 0", acks); end
  endtask

  task automatic test_late_request();
    int acks, raise_n, ack_n;
    acks = 0; ack_n = -1;
    while (!(cur_v() == VA + 1 && cur_h() == 5)) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL late_align n=%0d got=%h exp=%h", n, o, e); end
    end
    update_req = 1'b1;
    raise_n = n;
    for (int i = 0; i < FRAME; i++) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL late_cycle n=%0d got=%h exp=%h", n, o, e); end
      if (update_ack) begin acks++; ack_n = n; end
    end
    update_req = 1'b0;
    compared++;
    if (acks != 1 || ack_n - raise_n != FRAME - HT - 5) begin
      mismatched++;
      $display("FAIL late_ack acks=%0d delay=%0d exp acks=1 delay=%0d", acks, ack_n - raise_n, FRAME - HT - 5);
    end
  endtask

  task automatic test_reset_armed();
    int acks, len;
    acks = 0;
    while (!(cur_v() == 2 && cur_h() == 0)) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL rstarm_align n=%0d got=%h exp=%h", n, o, e); end
    end
    update_req = 1'b1;
    while (!(cur_v() == 3 && cur_h() == 0)) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL rstarm_armed n=%0d got=%h exp=%h", n, o, e); end
    end
    reset_n = 1'b0;
    update_req = 1'b0;
    len = 1 + int'($urandom_range(0, 2));
    for (int i = 0; i < len; i++) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL rstarm_hold n=%0d got=%h exp=%h", n, o, e); end
    end
    reset_n = 1'b1;
    compared++;
    if (hcount !== 11'd0 || vcount !== 10'd0) begin
      mismatched++; $display("FAIL rstarm_restart h=%0d v=%0d exp 0,0", hcount, vcount);
    end
    for (int i = 0; i < FRAME + HT; i++) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL rstarm_cycle n=%0d got=%h exp=%h", n, o, e); end
      if (update_ack) acks++;
    end
    compared++;
    if (acks != 0) begin mismatched++; $display("FAIL rstarm_no_ack acks=%0d exp 0", acks); end
  endtask

  task automatic test_frame_count();
    logic [15:0] exp_fc;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(); o = obs(); e = model_s(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL fcount_cycle n=%0d got=%h exp=%h", n, o, e); end
    end
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    exp_fc = 16'd3;
`else
    exp_fc = 16'd0;
`endif
    compared++;
    if (frame_count !== exp_fc) begin
      mismatched++; $display("FAIL frame_count_3 got=%0d exp=%0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        reset_n = 1'b0;
        update_req = 1'($urandom_range(0, 1));
        len = 1 + int'($urandom_range(0, 1));
        for (int i = 0; i < len; i++) begin
          tick(); o = obs(); e = model_s(); compared++;
          if (o !== e) begin mismatched++; $display("FAIL rand_reset n=%0d got=%h exp=%h", n, o, e); end
        end
        reset_n = 1'b1;
      end
      update_req = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, FRAME / 2));
      for (int i = 0; i < len; i++) begin
        tick(); o = obs(); e = model_s(); compared++;
        if (o !== e) begin mismatched++; $display("FAIL rand_cycle n=%0d got=%h exp=%h", n, o, e); end
      end
    end
    update_req = 1'b0;
  endtask

  task automatic test_default_timing();
    int lo_start, lo_len, bl_at_1024;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    lo_start = -1; lo_len = 0; bl_at_1024 = -1;
    for (int i = 0; i < 2 * 1344 + 4; i++) begin
      if (i > 0) tick();
      o = obs_d(); e = model(n, 1'b0, 1'b0, 1024, 24, 136, 160, 768, 3, 6, 29); compared++;
      if (o !== e) begin mismatched++; $display("FAIL default_cycle n=%0d got=%h exp=%h", n, o, e); end
      if (n < 1344 && !d_hsync) begin
        if (lo_start < 0) lo_start = int'(d_hcount);
        lo_len++;
      end
      if (n == 1024) bl_at_1024 = int'(d_blank);
    end
    compared++;
    if (lo_start != 1048 || lo_len != 136) begin
      mismatched++; $display("FAIL default_hsync start=%0d len=%0d exp start=1048 len=136", lo_start, lo_len);
    end
    compared++;
    if (bl_at_1024 != 1) begin
      mismatched++; $display("FAIL default_blank_1024 got=%0d exp=1", bl_at_1024);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_update_held();
    test_update_drop();
    test_late_request();
    test_reset_armed();
    test_frame_count();
    test_random();
    test_default_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 1024, visible pixels per line.
REQ-002 Parameter H_FP/H_SYNC/H_BP, 24/136/160, horizontal porch and sync widths; line total 1344.
REQ-003 Parameter V_ACTIVE, 768, visible lines per frame.
REQ-004 Parameter V_FP/V_SYNC/V_BP, 3/6/29, vertical porch and sync widths; frame total 806.
REQ-005 vclock  in  1  65 MHz pixel clock; the only clock.
REQ-006 reset_n  in  1  reset, synchronous to vclock, active-low.
REQ-007 update_req  in  1  producer requests a safe window to swap display state; level, held until acked.
REQ-008 hcount  out  11  horizontal pixel index 0..1343.
REQ-009 vcount  out  10  line index 0..805.
REQ-010 hsync  out  1  horizontal sync, active low.
REQ-011 vsync  out  1  vertical sync, active low.
REQ-012 blank  out  1  1 = outside the visible area; pixel must be black.
REQ-013 frame_start  out  1  one-cycle pulse at hcount=0, vcount=0.
REQ-014 update_ack  out  1  one-cycle grant pulse, issued only in vertical blanking.
REQ-015 frame_count  out  16  completed-frame counter (see Configuration).

Function
REQ-016 hcount shall increment by 1 every vclock and wrap from 1343 to 0.
REQ-017 vcount shall increment only on the cycle hcount wraps, and shall wrap from 805 to 0.
REQ-018 hsync shall be 0 exactly for hcount 1048..1183; otherwise 1.
REQ-019 vsync shall be 0 exactly for vcount 771..776; otherwise 1.
REQ-020 blank shall be 1 iff hcount>=1024 or vcount>=768.
REQ-021 All outputs shall be registered and mutually aligned, so hsync/vsync/blank/frame_start always describe the hcount/vcount values presented in the same cycle.
REQ-022 frame_start shall be 1 exactly when hcount=0 and vcount=0, including the first cycle after reset release.
REQ-023 Handshake FSM states: IDLE, ARMED, ACK.
REQ-024 IDLE -> ARMED when update_req=1 is sampled in IDLE.
REQ-025 ARMED -> ACK on the first cycle where vcount=768 and hcount=0. In ACK, update_ack=1 for exactly that cycle.
REQ-026 ACK -> IDLE unconditionally on the next cycle. While in IDLE the FSM shall ignore update_req for one cycle after ACK, so a held req yields at most one ack per frame.
REQ-027 A request raised during vertical blanking after vcount=768, hcount=0 shall be granted in the next frame's blanking, never mid-frame.
REQ-028 If update_req drops while ARMED, the FSM shall return to IDLE and no ack shall be issued.
REQ-029 Latency from req rise to ack: at most 1 frame plus 2 cycles (1,083,266 cycles).

Reset
REQ-030 While reset_n=0 at a vclock edge, the next state shall be: hcount=0, vcount=0, hsync=1, vsync=1, blank=0, frame_start=1, update_ack=0, frame_count=0, FSM=IDLE.
REQ-031 Reset asserted mid-frame or while ARMED shall discard the pending request without an ack. Counting shall restart from 0,0 on the first cycle after release.

Configuration
REQ-032 Macro VGA_TIMING_FRAME_COUNTER_EN defined: frame_count shall increment (mod 2^16) in the same cycle that vcount wraps 805->0.
REQ-033 Macro undefined: frame_count shall be held at constant 0 and no counter logic shall be synthesised. All other behaviour shall be unchanged.

Structure
REQ-034 The timing constants (totals, sync start/end, active sizes) and the FSM state enum shall live in shared package vga_pkg, reused by vga_writer-side blocks.
REQ-035 The horizontal/vertical counter pair shall be one sub-module, vga_counter. Sync decode and the FSM shall stay in vga_timing_gen.

Verification
REQ-036 Release reset -> cycle 0 shows hcount=0, vcount=0, frame_start=1, blank=0. hcount=1024 shows blank=1.
REQ-037 Run one line -> hsync low for exactly 136 cycles starting at hcount=1048. hcount 1343 is followed by 0 with vcount+1.
REQ-038 Run two frames -> frame_start pulses are exactly 1,083,264 cycles apart. vsync is low for 6 lines starting at vcount=771.
REQ-039 update_req raised at vcount=100 and held -> a single update_ack occurs at vcount=768, hcount=0. Keeping req held gives exactly one ack per frame.
REQ-040 update_req raised at vcount=400 and dropped at vcount=500 -> no ack. Reset_n pulsed low at vcount=300 while ARMED -> no ack, and counters restart from 0,0.
REQ-041 With VGA_TIMING_FRAME_COUNTER_EN, 3 frames from reset -> frame_count=3. Without the macro -> frame_count=0 throughout.
